aes128_decryptor: RTL and testbench

//  Iterative AES-128 decryptor (FIPS-197 inverse cipher); the receive-side counterpart of the encryptor.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_inv_round.sv | 44 ++++
 rtl/aes128_decryptor.sv | 131 +++++++++++++
 tb/tb_aes128_decryptor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon, byte substitution tables,
// GF(2^8) multiply helpers and the controller state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ADDKEY,
    ST_ROUND,
    ST_FINAL
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX_TBL [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX_TBL [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[b];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] added;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  // Byte n of the state is row n%4, column n/4; row r rotates right by r
  always_comb begin
    shifted = '0;
    mixed   = '0;
    a0      = 8'h00;
    a1      = 8'h00;
    a2      = 8'h00;
    a3      = 8'h00;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(r+4*c) -: 8] = inv_sbox(state_in[127-8*(r+4*((c+4-r)%4)) -: 8]);
      end
    end
    added = shifted ^ rk;
    for (int c = 0; c < 4; c++) begin
      a0 = added[127-32*c -: 8];
      a1 = added[119-32*c -: 8];
      a2 = added[111-32*c -: 8];
      a3 = added[103-32*c -: 8];
      mixed[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      mixed[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    state_out = last ? added : mixed;
  end

endmodule

// File: rtl/aes128_decryptor.sv
// Iterative AES-128 inverse cipher: expands the key schedule one round key
// per cycle (or reuses it when the key is unchanged), then runs the ten
// inverse rounds one per cycle.
module aes128_decryptor
  import aes_pkg::*;
#(
  parameter bit REUSE_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  state_t       state, state_next;
  logic [127:0] rk [0:10];
  logic [127:0] ct_reg;
  logic [127:0] s;
  logic [3:0]   kcnt;
  logic [3:0]   rcnt;
  logic         key_valid;
  logic         accept;
  logic         skip_exp;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  // Next round key from the previous one: RotWord, SubWord, Rcon, XOR chain
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign accept   = start && (state == ST_IDLE);
  assign skip_exp = REUSE_KEY && key_valid && (key == rk[0]);
  assign rk_next  = key_step(rk[kcnt - 4'd1], RCON[kcnt]);

  aes_inv_round u_round (
    .state_in  (s),
    .rk        (rk[rcnt]),
    .last      (state == ST_FINAL),
    .state_out (round_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = skip_exp ? ST_ADDKEY : ST_KEYEXP;
      ST_KEYEXP: if (kcnt == 4'(NR)) state_next = ST_ADDKEY;
      ST_ADDKEY: state_next = ST_ROUND;
      ST_ROUND:  if (rcnt == 4'd1) state_next = ST_FINAL;
      ST_FINAL:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Round-key storage; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept && !skip_exp) rk[0] <= key;
      else if (state == ST_KEYEXP) rk[kcnt] <= rk_next;
    end
  end

  // Counters, cipher state, result and key-valid tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt      <= 4'd1;
      rcnt      <= 4'd0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      plaintext <= '0;
      ct_reg    <= '0;
      s         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ct_reg <= ciphertext;
            done   <= 1'b0;
            kcnt   <= 4'd1;
            if (!skip_exp) key_valid <= 1'b0;
          end
        end
        ST_KEYEXP: begin
          if (kcnt != 4'(NR)) kcnt <= kcnt + 4'd1;
        end
        ST_ADDKEY: begin
          s    <= ct_reg ^ rk[NR];
          rcnt <= 4'(NR - 1);
        end
        ST_ROUND: begin
          s    <= round_out;
          rcnt <= rcnt - 4'd1;
        end
        ST_FINAL: begin
          plaintext <= round_out;
          done      <= 1'b1;
          key_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decryptor.sv
// Bench for aes128_decryptor: one instance with key reuse, one without,
// checked against a byte-level AES encryption model built from first principles.
module tb_aes128_decryptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ct;
  logic [127:0] key;
  logic [127:0] pt0, pt1;
  logic         done0, done1, busy0, busy1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] sbt [256];

  always #5 clk = ~clk;

  aes128_decryptor #(.REUSE_KEY(1'b1)) dut_reuse (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ct), .key(key),
    .plaintext(pt0), .done(done0), .busy(busy0)
  );

  aes128_decryptor #(.REUSE_KEY(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ct), .key(key),
    .plaintext(pt1), .done(done1), .busy(busy1)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    logic [7:0] sh;
    sh = {b[6:0], 1'b0};
    return b[7] ? (sh ^ 8'h1b) : sh;
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // S-box from the field inverse followed by the affine map
  task automatic build_sbox;
    logic [7:0] inv, c, o;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = o;
    end
  endtask

  // Forward AES-128 on a byte array; the DUT must invert this
  function automatic logic [127:0] model_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) tmp[n] = sbt[st[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a request for exactly one edge
  task automatic accept_op(input logic [127:0] c, input logic [127:0] k);
    ct    = c;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until each instance shows done; zero means it never did
  task automatic wait_done(input int n0, output int l0, output int l1);
    int n;
    n  = n0;
    l0 = 0;
    l1 = 0;
    while ((l0 == 0 || l1 == 0) && n < n0 + 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done0 && l0 == 0) l0 = n;
      if (done1 && l1 == 0) l1 = n;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    ct    = '0;
    key   = '0;
    repeat (3) @(posedge clk);
    #1;
    ct    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key   = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    n_vec++; if (done0 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
    n_vec++; if (pt0 !== 128'h0) begin n_bad++; $display("[TB] FAIL reset_pt: got %h expected 0", pt0); end
    n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy_full: got %b expected 0", busy1); end
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips_c;
    int l0, l1;
    logic [127:0] exp_pt;
    exp_pt = 128'h00112233445566778899aabbccddeeff;
    accept_op(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f);
    n_vec++; if (busy0 !== 1'b1) begin n_bad++; $display("[TB] FAIL fipsc_busy: got %b expected 1", busy0); end
    wait_done(0, l0, l1);
    n_vec++; if (l0 !== 21) begin n_bad++; $display("[TB] FAIL fipsc_latency: got %0d expected 21", l0); end
    n_vec++; if (pt0 !== exp_pt) begin n_bad++; $display("[TB] FAIL fipsc_pt: got %h expected %h", pt0, exp_pt); end
    n_vec++; if (pt1 !== exp_pt) begin n_bad++; $display("[TB] FAIL fipsc_pt_full: got %h expected %h", pt1, exp_pt); end
    n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("[TB] FAIL fipsc_busy_end: got %b expected 0", busy0); end
  endtask

  task automatic test_fips_b;
    int l0, l1;
    logic [127:0] exp_pt;
    exp_pt = 128'h3243f6a8885a308d313198a2e0370734;
    accept_op(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done(0, l0, l1);
    n_vec++; if (l0 !== 21) begin n_bad++; $display("[TB] FAIL fipsb_latency: got %0d expected 21", l0); end
    n_vec++; if (pt0 !== exp_pt) begin n_bad++; $display("[TB] FAIL fipsb_pt: got %h expected %h", pt0, exp_pt); end
  endtask

  task automatic test_reuse;
    int l0, l1;
    logic [127:0] exp_pt;
    exp_pt = 128'h3243f6a8885a308d313198a2e0370734;
    accept_op(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done(0, l0, l1);
    n_vec++; if (l0 !== 11) begin n_bad++; $display("[TB] FAIL reuse_latency: got %0d expected 11", l0); end
    n_vec++; if (l1 !== 21) begin n_bad++; $display("[TB] FAIL noreuse_latency: got %0d expected 21", l1); end
    n_vec++; if (pt0 !== exp_pt) begin n_bad++; $display("[TB] FAIL reuse_pt: got %h expected %h", pt0, exp_pt); end
    n_vec++; if (pt1 !== exp_pt) begin n_bad++; $display("[TB] FAIL noreuse_pt: got %h expected %h", pt1, exp_pt); end
  endtask

  task automatic test_round_trip;
    int l0, l1;
    logic [127:0] p, k;
    p = 128'h636f6d7061726368636f6d7061726368;
    k = 128'h737570657220736563726574206b6579;
    accept_op(model_encrypt(p, k), k);
    wait_done(0, l0, l1);
    n_vec++; if (pt0 !== p) begin n_bad++; $display("[TB] FAIL roundtrip_pt: got %h expected %h", pt0, p); end
    n_vec++; if (pt1 !== p) begin n_bad++; $display("[TB] FAIL roundtrip_pt_full: got %h expected %h", pt1, p); end
  endtask

  task automatic test_random;
    int l0, l1;
    logic [127:0] p, k;
    for (int it = 0; it < 4; it++) begin
      p = rand128();
      k = rand128();
      accept_op(model_encrypt(p, k), k);
      wait_done(0, l0, l1);
      n_vec++; if (pt0 !== p) begin n_bad++; $display("[TB] FAIL random_pt[%0d]: got %h expected %h", it, pt0, p); end
      n_vec++; if (pt1 !== p) begin n_bad++; $display("[TB] FAIL random_pt_full[%0d]: got %h expected %h", it, pt1, p); end
      p = rand128();
      accept_op(model_encrypt(p, k), k);
      wait_done(0, l0, l1);
      n_vec++; if (l0 !== 11) begin n_bad++; $display("[TB] FAIL random_reuse_lat[%0d]: got %0d expected 11", it, l0); end
      n_vec++; if (pt0 !== p) begin n_bad++; $display("[TB] FAIL random_reuse_pt[%0d]: got %h expected %h", it, pt0, p); end
    end
  endtask

  task automatic test_busy_ignore;
    int l0, l1;
    logic [127:0] p, k;
    p = rand128();
    k = rand128();
    accept_op(model_encrypt(p, k), k);
    repeat (4) @(posedge clk);
    #1;
    accept_op(rand128(), rand128());
    wait_done(5, l0, l1);
    n_vec++; if (l0 !== 21) begin n_bad++; $display("[TB] FAIL busyign_latency: got %0d expected 21", l0); end
    n_vec++; if (pt0 !== p) begin n_bad++; $display("[TB] FAIL busyign_pt: got %h expected %h", pt0, p); end
  endtask

  task automatic test_back_to_back;
    int l0, l1;
    logic [127:0] p1, p2, k;
    p1 = rand128();
    p2 = rand128();
    k  = rand128();
    accept_op(model_encrypt(p1, k), k);
    wait_done(0, l0, l1);
    n_vec++; if (pt0 !== p1) begin n_bad++; $display("[TB] FAIL b2b_first_pt: got %h expected %h", pt0, p1); end
    accept_op(model_encrypt(p2, k), k);
    n_vec++; if (done0 !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done0); end
    n_vec++; if (busy0 !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy0); end
    wait_done(0, l0, l1);
    n_vec++; if (l0 !== 11) begin n_bad++; $display("[TB] FAIL b2b_latency: got %0d expected 11", l0); end
    n_vec++; if (l1 !== 21) begin n_bad++; $display("[TB] FAIL b2b_latency_full: got %0d expected 21", l1); end
    n_vec++; if (pt0 !== p2) begin n_bad++; $display("[TB] FAIL b2b_second_pt: got %h expected %h", pt0, p2); end
    n_vec++; if (pt1 !== p2) begin n_bad++; $display("[TB] FAIL b2b_second_pt_full: got %h expected %h", pt1, p2); end
  endtask

  task automatic test_mid_reset;
    int l0, l1;
    logic [127:0] p, k;
    p = rand128();
    k = rand128();
    accept_op(model_encrypt(p, k), k);
    wait_done(0, l0, l1);
    p = rand128();
    accept_op(model_encrypt(p, k), k);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (done0 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_done: got %b expected 0", done0); end
    n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy0); end
    n_vec++; if (pt0 !== 128'h0) begin n_bad++; $display("[TB] FAIL midrst_pt: got %h expected 0", pt0); end
    accept_op(model_encrypt(p, k), k);
    wait_done(0, l0, l1);
    n_vec++; if (l0 !== 21) begin n_bad++; $display("[TB] FAIL midrst_relatency: got %0d expected 21", l0); end
    n_vec++; if (pt0 !== p) begin n_bad++; $display("[TB] FAIL midrst_pt_after: got %h expected %h", pt0, p); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ct    = '0;
    key   = '0;
    build_sbox();
    $display("[TB] starting aes128_decryptor bench");
    test_reset();
    test_fips_c();
    test_fips_b();
    test_reuse();
    test_round_trip();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
